// File: rtl/dmi_target.sv
`default_nettype none
// ============================================================================
// Module   : dmi_target
// Purpose  : Minimal RISC-V debug-module DMI target. Accepts one DMI request
//            at a time and decodes it against a small register map: data0/1,
//            dmcontrol, dmstatus and abstractcs. It returns the response after
//            a configurable number of extra wait cycles.
// Ports    : clk, reset (async, active-low)
//            dmi_rst_i                         - synchronous DMI clear
//            dmi_req_i / _valid_i / _ready_o   - {addr[6:0], data[31:0], op[1:0]}
//            dmi_resp_o / _valid_o / _ready_i  - {data[31:0], resp[1:0]}
//            hart_halted_i, hart_resumeack_i   - hart status inputs
//            dmactive_o, ndmreset_o, haltreq_o, resumereq_o - DM control levels
// Revision : 1.0 - initial release
// ============================================================================
module dmi_target #(
   parameter int RespDelay = 0,
   parameter int NumData   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dmi_rst_i,
   input  logic [40:0] dmi_req_i,
   input  logic        dmi_req_valid_i,
   output logic        dmi_req_ready_o,
   output logic [33:0] dmi_resp_o,
   output logic        dmi_resp_valid_o,
   input  logic        dmi_resp_ready_i,
   input  logic        hart_halted_i,
   input  logic        hart_resumeack_i,
   output logic        dmactive_o,
   output logic        ndmreset_o,
   output logic        haltreq_o,
   output logic        resumereq_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam logic [6:0] c_addr_data0      = 7'h04;
   localparam logic [6:0] c_addr_data1      = 7'h05;
   localparam logic [6:0] c_addr_dmcontrol  = 7'h10;
   localparam logic [6:0] c_addr_dmstatus   = 7'h11;
   localparam logic [6:0] c_addr_abstractcs = 7'h16;

   localparam logic [1:0] c_op_read  = 2'd1;
   localparam logic [1:0] c_op_write = 2'd2;
   localparam logic [1:0] c_op_bad   = 2'd3;

   // The counter is loaded with one less than the delay, so WAIT lasts exactly
   // RespDelay cycles: it leaves on the cycle the counter is already zero.
   localparam logic [3:0] c_delay_m1   = (RespDelay > 0) ? 4'(RespDelay - 1) : 4'd0;
   localparam logic [3:0] c_datacount  = 4'(NumData);
   localparam bit         c_has_data1  = (NumData == 2);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [33:0] resp_q, resp_d;
   logic [31:0] data0_q, data0_d;
   logic [31:0] data1_q, data1_d;
   logic        dmactive_q, dmactive_d;
   logic        ndmreset_q, ndmreset_d;
   logic        haltreq_q, haltreq_d;
   logic        resumereq_q, resumereq_d;
   logic        resumeack_q, resumeack_d;

   logic [6:0]  w_addr;
   logic [31:0] w_wdata;
   logic [1:0]  w_op;
   logic        w_accept;
   logic [31:0] w_rdata;
   logic [31:0] w_dmstatus;
   logic [31:0] w_dmcontrol;
   logic [31:0] w_abstractcs;

   assign w_addr  = dmi_req_i[40:34];
   assign w_wdata = dmi_req_i[33:2];
   assign w_op    = dmi_req_i[1:0];

   // A DMI clear on the same edge takes precedence over acceptance.
   assign w_accept = (state_q == ST_IDLE) && dmi_req_valid_i && !dmi_rst_i;

   assign w_dmstatus   = {14'b0, resumeack_q, resumeack_q, 4'b0,
                          !hart_halted_i, !hart_halted_i, hart_halted_i, hart_halted_i,
                          1'b1, 3'b0, 4'd2};
   // resumereq is a write-only trigger and always reads back as 0.
   assign w_dmcontrol  = {haltreq_q, 1'b0, 28'b0, ndmreset_q, dmactive_q};
   assign w_abstractcs = {3'b0, 5'd0, 11'b0, 1'b0, 1'b0, 3'd0, 4'b0, c_datacount};

   // -------------------------------------------------------------------------
   // Read data mux
   // -------------------------------------------------------------------------
   always_comb begin
      w_rdata = 32'd0;
      case (w_addr)
         c_addr_data0:      w_rdata = data0_q;
         c_addr_data1:      w_rdata = c_has_data1 ? data1_q : 32'd0;
         c_addr_dmcontrol:  w_rdata = w_dmcontrol;
         c_addr_dmstatus:   w_rdata = w_dmstatus;
         c_addr_abstractcs: w_rdata = w_abstractcs;
         default:           w_rdata = 32'd0;
      endcase
   end

   // -------------------------------------------------------------------------
   // Next-state, response capture and register side effects
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      resp_d      = resp_q;
      data0_d     = data0_q;
      data1_d     = data1_q;
      dmactive_d  = dmactive_q;
      ndmreset_d  = ndmreset_q;
      haltreq_d   = haltreq_q;
      resumereq_d = resumereq_q;
      resumeack_d = resumeack_q;

      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               case (w_op)
                  c_op_read: resp_d = {w_rdata, 2'b00};
                  c_op_bad:  resp_d = {32'd0, 2'b10};
                  default:   resp_d = 34'd0;
               endcase
               state_d = (RespDelay > 0) ? ST_WAIT : ST_RESP;
               cnt_d   = c_delay_m1;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (dmi_resp_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (dmi_rst_i) begin
         state_d = ST_IDLE;
         cnt_d   = 4'd0;
      end

      // Hart acknowledge is evaluated first so that a coincident resume
      // write below overrides it.
      if (resumereq_q && hart_resumeack_i) begin
         resumereq_d = 1'b0;
         resumeack_d = 1'b1;
      end

      if (w_accept && (w_op == c_op_write)) begin
         case (w_addr)
            c_addr_dmcontrol: begin
               if (!w_wdata[0]) begin
                  // Deactivation resets the whole debug module state.
                  dmactive_d  = 1'b0;
                  data0_d     = 32'd0;
                  data1_d     = 32'd0;
                  ndmreset_d  = 1'b0;
                  haltreq_d   = 1'b0;
                  resumereq_d = 1'b0;
                  resumeack_d = 1'b0;
               end else if (!dmactive_q) begin
                  // While inactive, only the activation bit is accepted.
                  dmactive_d = 1'b1;
               end else begin
                  ndmreset_d = w_wdata[1];
                  haltreq_d  = w_wdata[31];
                  if (w_wdata[30] && !w_wdata[31]) begin
                     resumereq_d = 1'b1;
                     resumeack_d = 1'b0;
                  end
               end
            end
            c_addr_data0: begin
               if (dmactive_q) begin
                  data0_d = w_wdata;
               end
            end
            c_addr_data1: begin
               if (dmactive_q && c_has_data1) begin
                  data1_d = w_wdata;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         resp_q      <= 34'd0;
         data0_q     <= 32'd0;
         data1_q     <= 32'd0;
         dmactive_q  <= 1'b0;
         ndmreset_q  <= 1'b0;
         haltreq_q   <= 1'b0;
         resumereq_q <= 1'b0;
         resumeack_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         resp_q      <= resp_d;
         data0_q     <= data0_d;
         data1_q     <= data1_d;
         dmactive_q  <= dmactive_d;
         ndmreset_q  <= ndmreset_d;
         haltreq_q   <= haltreq_d;
         resumereq_q <= resumereq_d;
         resumeack_q <= resumeack_d;
      end
   end

   assign dmi_req_ready_o  = (state_q == ST_IDLE);
   assign dmi_resp_valid_o = (state_q == ST_RESP);
   assign dmi_resp_o       = resp_q;
   assign dmactive_o       = dmactive_q;
   assign ndmreset_o       = ndmreset_q;
   assign haltreq_o        = haltreq_q;
   assign resumereq_o      = resumereq_q;

endmodule
`default_nettype wire

// File: tb/tb_dmi_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmi_target
// Purpose  : Directed self-checking bench for dmi_target. Instance 0 uses
//            RespDelay=3, NumData=2; instance 1 uses RespDelay=0, NumData=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmi_target;

   logic        clk = 1'b0;
   logic        reset;
   logic        dmi_rst;
   logic [40:0] req;
   logic [1:0]  req_valid;
   logic        resp_ready;
   logic        hart_halted;
   logic        hart_resumeack;

   logic [1:0]  req_ready;
   logic [1:0]  resp_valid;
   logic [33:0] resp [2];
   logic [1:0]  dmactive, ndmreset, haltreq, resumereq;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   dmi_target #(.RespDelay(3), .NumData(2)) u_dut0 (
      .clk(clk), .reset(reset), .dmi_rst_i(dmi_rst),
      .dmi_req_i(req), .dmi_req_valid_i(req_valid[0]), .dmi_req_ready_o(req_ready[0]),
      .dmi_resp_o(resp[0]), .dmi_resp_valid_o(resp_valid[0]), .dmi_resp_ready_i(resp_ready),
      .hart_halted_i(hart_halted), .hart_resumeack_i(hart_resumeack),
      .dmactive_o(dmactive[0]), .ndmreset_o(ndmreset[0]),
      .haltreq_o(haltreq[0]), .resumereq_o(resumereq[0])
   );

   dmi_target #(.RespDelay(0), .NumData(1)) u_dut1 (
      .clk(clk), .reset(reset), .dmi_rst_i(dmi_rst),
      .dmi_req_i(req), .dmi_req_valid_i(req_valid[1]), .dmi_req_ready_o(req_ready[1]),
      .dmi_resp_o(resp[1]), .dmi_resp_valid_o(resp_valid[1]), .dmi_resp_ready_i(resp_ready),
      .hart_halted_i(hart_halted), .hart_resumeack_i(hart_resumeack),
      .dmactive_o(dmactive[1]), .ndmreset_o(ndmreset[1]),
      .haltreq_o(haltreq[1]), .resumereq_o(resumereq[1])
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete DMI transaction. Inputs change 1 time unit after a rising
   // edge; outputs are sampled at the same point.
   task automatic xfer(input int sel, input logic [6:0] addr, input logic [1:0] op,
                       input logic [31:0] data, input int hold, input logic ack,
                       output logic [33:0] r, output int lat);
      req            = {addr, data, op};
      req_valid[sel] = 1'b1;
      resp_ready     = (hold == 0);
      hart_resumeack = ack;
      @(posedge clk); #1;
      req_valid      = 2'b00;
      hart_resumeack = 1'b0;
      lat = 1;
      while (!resp_valid[sel] && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("resp_valid_seen", resp_valid[sel], 1'b1);
      chk("latency", lat, (sel == 0) ? 4 : 1);
      r = resp[sel];
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_stable", {resp_valid[sel], req_ready[sel], resp[sel]}, {1'b1, 1'b0, r});
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      chk("resp_done", {resp_valid[sel], req_ready[sel]}, 2'b01);
   endtask

   task automatic wr(input int sel, input logic [6:0] a, input logic [31:0] d);
      logic [33:0] r;
      int lat;
      xfer(sel, a, 2'd2, d, 0, 1'b0, r, lat);
      chk("wr_resp", r, 34'h0);
   endtask

   task automatic rd(input int sel, input logic [6:0] a, input logic [31:0] e, input string tag);
      logic [33:0] r;
      int lat;
      xfer(sel, a, 2'd1, 32'h0, 0, 1'b0, r, lat);
      chk(tag, r, {e, 2'b00});
   endtask

   initial begin
      logic [33:0] r;
      int lat;
      reset = 1'b0; dmi_rst = 1'b0; req = '0; req_valid = 2'b00;
      resp_ready = 1'b1; hart_halted = 1'b0; hart_resumeack = 1'b0;

      // ---- reset state ----
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", req_ready, 2'b11);
      chk("rst_valid", resp_valid, 2'b00);
      chk("rst_resp0", resp[0], 34'h0);
      chk("rst_ctrl", {dmactive[0], ndmreset[0], haltreq[0], resumereq[0]}, 4'b0000);
      reset = 1'b1;
      @(posedge clk); #1;

      // ---- activation, then read of data0 ----
      wr(0, 7'h10, 32'h0000_0001);
      chk("dmactive_set", dmactive[0], 1'b1);
      rd(0, 7'h04, 32'h0, "rd_data0_init");

      // ---- data registers and abstractcs ----
      wr(0, 7'h04, 32'hDEAD_BEEF);
      rd(0, 7'h04, 32'hDEAD_BEEF, "rd_data0_deadbeef");
      wr(0, 7'h05, 32'h1234_5678);
      rd(0, 7'h05, 32'h1234_5678, "rd_data1");
      rd(0, 7'h16, 32'h0000_0002, "rd_abstractcs2");
      rd(0, 7'h3F, 32'h0, "rd_unmapped");

      // ---- back-pressure: response held for 5 cycles ----
      xfer(0, 7'h04, 2'd1, 32'h0, 5, 1'b0, r, lat);
      chk("rd_backpressure", r, {32'hDEAD_BEEF, 2'b00});

      // ---- halt request and dmstatus halted bits ----
      hart_halted = 1'b1;
      wr(0, 7'h10, 32'h8000_0001);
      chk("haltreq_set", haltreq[0], 1'b1);
      rd(0, 7'h10, 32'h8000_0001, "rd_dmcontrol_halt");
      rd(0, 7'h11, 32'h0000_0382, "rd_dmstatus_halted");
      wr(0, 7'h10, 32'hC000_0001);
      chk("resume_with_halt_ignored", {haltreq[0], resumereq[0]}, 2'b10);

      // ---- resume handshake ----
      hart_halted = 1'b0;
      wr(0, 7'h10, 32'h4000_0001);
      chk("resumereq_set", {haltreq[0], resumereq[0]}, 2'b01);
      rd(0, 7'h10, 32'h0000_0001, "rd_dmcontrol_resume_reads0");
      hart_resumeack = 1'b1;
      @(posedge clk); #1;
      hart_resumeack = 1'b0;
      chk("resumereq_cleared", resumereq[0], 1'b0);
      rd(0, 7'h11, 32'h0003_0C82, "rd_dmstatus_resumeack");
      wr(0, 7'h10, 32'h4000_0001);
      rd(0, 7'h11, 32'h0000_0C82, "rd_dmstatus_ack_cleared");
      // Acknowledge coincides with a new resume write: the write must win.
      xfer(0, 7'h10, 2'd2, 32'h4000_0001, 0, 1'b1, r, lat);
      chk("coincide_resumereq", resumereq[0], 1'b1);
      rd(0, 7'h11, 32'h0000_0C82, "rd_dmstatus_coincide");
      hart_resumeack = 1'b1;
      @(posedge clk); #1;
      hart_resumeack = 1'b0;
      chk("resumereq_cleared2", resumereq[0], 1'b0);

      // ---- failed op, deactivation clears state ----
      xfer(0, 7'h04, 2'd3, 32'h1111_1111, 0, 1'b0, r, lat);
      chk("op3_resp", r, 34'h2);
      rd(0, 7'h04, 32'hDEAD_BEEF, "rd_data0_after_op3");
      wr(0, 7'h10, 32'h8000_0003);
      chk("ctrl_levels", {ndmreset[0], haltreq[0]}, 2'b11);
      wr(0, 7'h10, 32'h0000_0000);
      chk("deactivate", {dmactive[0], ndmreset[0], haltreq[0], resumereq[0]}, 4'b0000);
      wr(0, 7'h04, 32'h5555_5555);
      wr(0, 7'h10, 32'h8000_0003);
      chk("inactive_only_dmactive", {dmactive[0], ndmreset[0], haltreq[0]}, 3'b100);
      rd(0, 7'h04, 32'h0, "rd_data0_cleared");
      rd(0, 7'h05, 32'h0, "rd_data1_cleared");
      rd(0, 7'h11, 32'h0000_0C82, "rd_dmstatus_flag_cleared");

      // ---- async reset during WAIT ----
      wr(0, 7'h04, 32'hCAFE_F00D);
      req = {7'h04, 32'h0, 2'd1};
      req_valid[0] = 1'b1;
      @(posedge clk); #1;
      req_valid = 2'b00;
      chk("in_wait_not_ready", {req_ready[0], resp_valid[0]}, 2'b00);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("async_rst_state", {req_ready[0], resp_valid[0], dmactive[0]}, 3'b100);
      chk("async_rst_resp", resp[0], 34'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      wr(0, 7'h10, 32'h0000_0001);
      rd(0, 7'h04, 32'h0, "rd_data0_after_reset");

      // ---- DMI clear in IDLE blocks acceptance ----
      req = {7'h04, 32'h0, 2'd1};
      req_valid[0] = 1'b1;
      dmi_rst = 1'b1;
      @(posedge clk); #1;
      dmi_rst = 1'b0;
      req_valid = 2'b00;
      chk("dmi_rst_no_accept", {req_ready[0], resp_valid[0]}, 2'b10);

      // ---- DMI clear during RESP ----
      wr(0, 7'h04, 32'h0BAD_CAFE);
      req = {7'h04, 32'h0, 2'd1};
      req_valid[0] = 1'b1;
      resp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 2'b00;
      for (int i = 0; i < 10 && !resp_valid[0]; i++) begin
         @(posedge clk); #1;
      end
      chk("resp_pending", resp_valid[0], 1'b1);
      dmi_rst = 1'b1;
      @(posedge clk); #1;
      dmi_rst = 1'b0;
      resp_ready = 1'b1;
      chk("dmi_rst_abort", {req_ready[0], resp_valid[0]}, 2'b10);
      rd(0, 7'h04, 32'h0BAD_CAFE, "rd_data0_kept");
      chk("dmactive_kept", dmactive[0], 1'b1);

      // ---- instance 1: zero delay, single data register ----
      wr(1, 7'h10, 32'h0000_0001);
      chk("dut1_active", dmactive[1], 1'b1);
      wr(1, 7'h05, 32'h1234_5678);
      rd(1, 7'h05, 32'h0, "dut1_rd_data1");
      rd(1, 7'h16, 32'h0000_0001, "dut1_rd_abstractcs");
      wr(1, 7'h04, 32'hA5A5_5A5A);
      rd(1, 7'h04, 32'hA5A5_5A5A, "dut1_rd_data0");
      xfer(1, 7'h04, 2'd0, 32'h0, 0, 1'b0, r, lat);
      chk("dut1_nop", r, 34'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dmi_target.md
DMI_TARGET -- requirements
Module: dmi_target

Interface
REQ-001 Parameter RespDelay, default 0, SHALL set the extra wait cycles between request acceptance and response-valid (legal range 0-15).
REQ-002 Parameter NumData, default 2, SHALL set the number of implemented abstract data registers (1 or 2).
REQ-003 clk  input  1  SHALL be the single block clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 dmi_rst_i  input  1  SHALL be the synchronous DMI clear from the DTM.
REQ-006 dmi_req_i  input  41  SHALL carry the request as {addr[40:34], data[33:2], op[1:0]}.
REQ-007 dmi_req_valid_i  input  1 / dmi_req_ready_o  output  1  SHALL form the request valid/ready handshake.
REQ-008 dmi_resp_o  output  34  SHALL carry the response as {data[33:2], resp[1:0]}.
REQ-009 dmi_resp_valid_o  output  1 / dmi_resp_ready_i  input  1  SHALL form the response valid/ready handshake.
REQ-010 hart_halted_i  input  1  SHALL carry the hart halted status; hart_resumeack_i  input  1  SHALL pulse when the hart has resumed.
REQ-011 dmactive_o, ndmreset_o, haltreq_o, resumereq_o  output  1 each  SHALL drive the matching DM control levels.

Function
REQ-012 The FSM SHALL have three states:
- IDLE: dmi_req_ready_o=1.
- WAIT: RespDelay countdown.
- RESP: dmi_resp_valid_o=1.
REQ-013 From IDLE, a request SHALL be accepted on a clk edge where valid&ready; the next state SHALL be WAIT if RespDelay>0, else RESP.
REQ-014 WAIT SHALL load a 4-bit counter with RespDelay-1 on entry, decrement it each cycle, and go to RESP when the counter reaches 0.
REQ-015 In RESP, dmi_resp_o and dmi_resp_valid_o SHALL stay stable until resp_valid&resp_ready, then return to IDLE; no new request SHALL be accepted before that cycle.
REQ-016 Read data and all write side effects SHALL be taken at the acceptance edge.
- Response latency: 1+RespDelay cycles after acceptance when dmi_resp_ready_i=1.
REQ-017 op encoding and response:
- op 0 (nop): response data 0, resp 0.
- op 1 (read): response data = register value, resp 0.
- op 2 (write): performs the write; response data 0, resp 0.
- op 3: no state change; response data 0, resp 2 (failed).
REQ-018 Register map:
- 0x04 data0 (R/W).
- 0x05 data1 (R/W when NumData=2, else reads 0, writes ignored).
- 0x10 dmcontrol: bit0 dmactive, bit1 ndmreset, bit30 resumereq, bit31 haltreq.
- 0x11 dmstatus (read-only).
- 0x16 abstractcs: reads {3'b0, progbufsize 5'd0, 11'b0, busy 0, 1'b0, cmderr 3'd0, 4'b0, datacount NumData[3:0]}.
- All other addresses: read 0, writes ignored, resp 0.
REQ-019 dmstatus SHALL read:
- [3:0]=2, bit7=1.
- bit8/bit9 = hart_halted_i; bit10/bit11 = !hart_halted_i.
- bit16/bit17 = resumeack flag.
- All other bits 0.
REQ-020 While dmactive=0, writes SHALL be ignored except a dmcontrol write; that write SHALL update only dmactive.
REQ-021 A dmcontrol write with dmactive=0 SHALL clear data0, data1, ndmreset, haltreq, resumereq and the resumeack flag.
REQ-022 haltreq and ndmreset SHALL be levels written directly from the write data.
REQ-023 A dmcontrol write with resumereq=1 and haltreq=0 SHALL set resumereq_o and clear the resumeack flag.
- resumereq=1 together with haltreq=1 SHALL be ignored.
REQ-024 resumereq_o SHALL clear, and the resumeack flag SHALL set, on the first edge where hart_resumeack_i=1 while resumereq_o=1.
- If that edge coincides with a REQ-023 write, the write SHALL win.
REQ-025 dmcontrol reads SHALL return resumereq as 0 and all other fields as stored.

Reset
REQ-026 reset low SHALL immediately force:
- state IDLE, counter 0;
- dmi_resp_valid_o=0, dmi_resp_o=0;
- all registers, flags and control outputs to 0;
- dmi_req_ready_o SHALL read 1 while in IDLE.
REQ-027 dmi_rst_i=1 at a clk edge SHALL abort any in-flight transaction: state IDLE, dmi_resp_valid_o=0, no request accepted that edge; DM registers SHALL be unchanged.

Verification
REQ-028 Write 0x10 data 0x00000001, then read 0x04 -> dmactive_o=1; read response {0x00000000, 0}.
REQ-029 dmactive=1; write 0x04 data 0xDEADBEEF; read 0x04 with RespDelay=3 -> read response data 0xDEADBEEF, resp 0; dmi_resp_valid_o asserts exactly 4 cycles after acceptance.
REQ-030 Response pending with dmi_resp_ready_i=0 for 5 cycles -> dmi_resp_o stable, dmi_req_ready_o=0 throughout; completes the cycle ready rises.
REQ-031 Write 0x10 data 0x40000001, hold hart_resumeack_i=1 for 1 cycle, read 0x11 -> resumereq_o falls; dmstatus bits16/17=1; bits [3:0]=2.
REQ-032 Send op 3 to 0x04 -> resp 2, data0 unchanged; then write 0x10 data 0x00000000 -> data0 reads 0 after re-activation.
REQ-033 Assert reset low during WAIT, and separately dmi_rst_i during RESP -> both return to IDLE with valid=0; registers cleared only by reset.
